// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the architectural register file.
package reg_file_pkg;

    localparam int REG_NUM       = 32;
    localparam int ADDR_W        = 5;
    localparam int DATA_W        = 32;
    localparam int PENDING_CNT_W = 6;

    localparam logic [ADDR_W-1:0] REG_ZERO  = '0;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;
    localparam logic              ENABLE    = 1'b1;
    localparam logic              DISABLE   = 1'b0;

    // Number of set bits in the pending vector.
    function automatic logic [PENDING_CNT_W-1:0] popcount(input logic [REG_NUM-1:0] v);
        logic [PENDING_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            cnt = cnt + PENDING_CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// write-back, with issue taking priority when both hit the same register.
module reg_scoreboard
    import reg_file_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_setEnable,
    input  logic [ADDR_W-1:0]        i_setAddr,
    input  logic                     i_clearEnable,
    input  logic [ADDR_W-1:0]        i_clearAddr,
    output logic [REG_NUM-1:0]       o_pending,
    output logic [PENDING_CNT_W-1:0] o_pendingCount
);

    logic [REG_NUM-1:0]       pending_q, pending_d;
    logic [PENDING_CNT_W-1:0] count_q;

    // Next pending vector: clear first so a same-cycle set on that register wins.
    always_comb begin
        pending_d = pending_q;
        if (i_clearEnable && i_clearAddr != REG_ZERO) begin
            pending_d[i_clearAddr] = DISABLE;
        end
        if (i_setEnable && i_setAddr != REG_ZERO) begin
            pending_d[i_setAddr] = ENABLE;
        end
        pending_d[0] = DISABLE;
    end

    // Pending bits and their registered population count move together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= popcount(pending_d);
        end
    end

    assign o_pending      = pending_q;
    assign o_pendingCount = count_q;

endmodule

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with write-back
// bypass, one synchronous write port, and a pending-write scoreboard.
module reg_file
    import reg_file_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [ADDR_W-1:0]        i_readAddrLeft,
    input  logic [ADDR_W-1:0]        i_readAddrRight,
    output logic [DATA_W-1:0]        o_readValueLeft,
    output logic [DATA_W-1:0]        o_readValueRight,
    output logic                     o_busyLeft,
    output logic                     o_busyRight,
    input  logic                     i_writeEnable,
    input  logic [ADDR_W-1:0]        i_writeAddr,
    input  logic [DATA_W-1:0]        i_writeValue,
    input  logic                     i_issueEnable,
    input  logic [ADDR_W-1:0]        i_issueDest,
    input  logic                     i_stall,
    output logic [PENDING_CNT_W-1:0] o_pendingCount
);

    // r0 has no storage; it is hardwired to zero on the read side.
    logic [DATA_W-1:0]  regs_q [1:REG_NUM-1];
    logic [REG_NUM-1:0] pending;
    logic               hitLeft, hitRight;

    // Write-back port; writes to r0 are dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs_q[i] <= ZERO_WORD;
            end
        end else if (i_writeEnable && i_writeAddr != REG_ZERO) begin
            regs_q[i_writeAddr] <= i_writeValue;
        end
    end

    // Bypass hits: the write-back in flight this cycle targets the read address.
    always_comb begin
        hitLeft  = i_writeEnable && (i_writeAddr == i_readAddrLeft)  && (i_readAddrLeft  != REG_ZERO);
        hitRight = i_writeEnable && (i_writeAddr == i_readAddrRight) && (i_readAddrRight != REG_ZERO);
    end

    // Read ports: zero for r0, bypassed write data on a hit, stored value otherwise.
    always_comb begin
        o_readValueLeft  = ZERO_WORD;
        o_readValueRight = ZERO_WORD;
        if (hitLeft) begin
            o_readValueLeft = i_writeValue;
        end else if (i_readAddrLeft != REG_ZERO) begin
            o_readValueLeft = regs_q[i_readAddrLeft];
        end
        if (hitRight) begin
            o_readValueRight = i_writeValue;
        end else if (i_readAddrRight != REG_ZERO) begin
            o_readValueRight = regs_q[i_readAddrRight];
        end
    end

    // A register whose result is arriving this cycle is no longer a hazard.
    always_comb begin
        o_busyLeft  = pending[i_readAddrLeft]  & ~hitLeft;
        o_busyRight = pending[i_readAddrRight] & ~hitRight;
    end

    reg_scoreboard u_scoreboard (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_setEnable    (i_issueEnable & ~i_stall),
        .i_setAddr      (i_issueDest),
        .i_clearEnable  (i_writeEnable),
        .i_clearAddr    (i_writeAddr),
        .o_pending      (pending),
        .o_pendingCount (o_pendingCount)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a behavioural register/pending model is checked
// against the DUT on every negative edge, plus hand-computed literal checks.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  raL = '0, raR = '0;
    logic [31:0] rvL, rvR;
    logic        bL, bR;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wv = '0;
    logic        ie = 1'b0;
    logic [4:0]  idest = '0;
    logic        stall = 1'b0;
    logic [5:0]  pcnt;

    int nvec = 0;
    int nerr = 0;

    // Behavioural model state.
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    always #5 clk = ~clk;

    reg_file dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_readAddrLeft   (raL),
        .i_readAddrRight  (raR),
        .o_readValueLeft  (rvL),
        .o_readValueRight (rvR),
        .o_busyLeft       (bL),
        .o_busyRight      (bR),
        .i_writeEnable    (we),
        .i_writeAddr      (wa),
        .i_writeValue     (wv),
        .i_issueEnable    (ie),
        .i_issueDest      (idest),
        .i_stall          (stall),
        .o_pendingCount   (pcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: register writes, then scoreboard with issue overriding write-back.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) begin
                m_regs[wa] = wv;
                m_pend[wa] = 1'b0;
            end
            if (ie && !stall && idest != 0) m_pend[idest] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wv;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return m_pend[a] && !(we && wa == a && a != 0);
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    // Compare process: every cycle, mid-period, against the model.
    always @(negedge clk) begin
        chk("model_readL", rvL, exp_read(raL));
        chk("model_readR", rvR, exp_read(raR));
        chk("model_busyL", 32'(bL), 32'(exp_busy(raL)));
        chk("model_busyR", 32'(bR), 32'(exp_busy(raR)));
        chk("model_count", 32'(pcnt), 32'(exp_count()));
    end

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        #12 rst = 1'b0;
        adv();

        // 1: reset state
        raL = 5'd0; raR = 5'd5;
        settle();
        chk("rst_readL0", rvL, 32'h0);
        chk("rst_readR5", rvR, 32'h0);
        chk("rst_busyR", 32'(bR), 32'h0);
        chk("rst_count", 32'(pcnt), 32'h0);
        raL = 5'd31;
        settle();
        chk("rst_readL31", rvL, 32'h0);

        // 2: write r7, then attempt r0
        adv();
        we = 1'b1; wa = 5'd7; wv = 32'hDEADBEEF;
        adv();
        we = 1'b0; raL = 5'd7; raR = 5'd7;
        settle();
        chk("r7_left", rvL, 32'hDEADBEEF);
        chk("r7_right", rvR, 32'hDEADBEEF);
        adv();
        we = 1'b1; wa = 5'd0; wv = 32'h1234; raL = 5'd0;
        settle();
        chk("r0_bypass", rvL, 32'h0);
        adv();
        we = 1'b0;
        settle();
        chk("r0_after", rvL, 32'h0);

        // 3: same-cycle bypass on left, right unaffected
        adv();
        we = 1'b1; wa = 5'd3; wv = 32'hA5A5A5A5; raL = 5'd3; raR = 5'd4;
        settle();
        chk("bypass_left", rvL, 32'hA5A5A5A5);
        chk("bypass_right", rvR, 32'h0);
        adv();
        we = 1'b0;
        settle();
        chk("r3_stored", rvL, 32'hA5A5A5A5);

        // 4: issue, stalled issue, write-back clear
        adv();
        ie = 1'b1; idest = 5'd9;
        adv();
        ie = 1'b0; raL = 5'd9;
        settle();
        chk("r9_busy", 32'(bL), 32'h1);
        chk("r9_count", 32'(pcnt), 32'h1);
        adv();
        ie = 1'b1; stall = 1'b1; idest = 5'd10; raR = 5'd10;
        adv();
        ie = 1'b0; stall = 1'b0;
        settle();
        chk("r10_stalled", 32'(bR), 32'h0);
        chk("stall_count", 32'(pcnt), 32'h1);
        adv();
        we = 1'b1; wa = 5'd9; wv = 32'h99;
        settle();
        chk("wb_not_busy", 32'(bL), 32'h0);
        chk("wb_bypass", rvL, 32'h99);
        adv();
        we = 1'b0;
        settle();
        chk("wb_cleared", 32'(bL), 32'h0);
        chk("wb_count", 32'(pcnt), 32'h0);

        // 5: set beats clear on the same register; r0 issue ignored
        adv();
        ie = 1'b1; idest = 5'd9;
        adv();
        we = 1'b1; wa = 5'd9; wv = 32'h77;
        adv();
        ie = 1'b0; we = 1'b0;
        settle();
        chk("setwins_busy", 32'(bL), 32'h1);
        chk("setwins_data", rvL, 32'h77);
        chk("setwins_count", 32'(pcnt), 32'h1);
        adv();
        ie = 1'b1; idest = 5'd0;
        adv();
        ie = 1'b0;
        settle();
        chk("r0_issue_count", 32'(pcnt), 32'h1);

        // 6: mark r1..r4, write r2, async reset mid-cycle
        adv();
        ie = 1'b1; idest = 5'd1; we = 1'b1; wa = 5'd2; wv = 32'h55;
        adv();
        we = 1'b0; idest = 5'd2;
        adv();
        idest = 5'd3;
        adv();
        idest = 5'd4;
        adv();
        ie = 1'b0; raL = 5'd2; raR = 5'd4;
        settle();
        chk("pre_rst_count", 32'(pcnt), 32'h5);
        chk("pre_rst_r2", rvL, 32'h55);
        chk("pre_rst_busyR", 32'(bR), 32'h1);
        rst = 1'b1;
        #2;
        chk("async_count", 32'(pcnt), 32'h0);
        chk("async_r2", rvL, 32'h0);
        chk("async_busyL", 32'(bL), 32'h0);
        chk("async_busyR", 32'(bR), 32'h0);
        adv();
        rst = 1'b0;
        settle();
        chk("post_rst_r2", rvL, 32'h0);
        chk("post_rst_count", 32'(pcnt), 32'h0);

        adv();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
